qspi_sram_responder: RTL
========================

# qspi_sram_responder

Synthesizable QSPI target that emulates the external quad-SPI SRAM driven by the team's SPI controller: it decodes the 0x38 quad-write and 0xEB quad-read commands from the pin interface and translates them into byte accesses on a simple synchronous memory port. It sits on the far side of the QSPI pins, in the FPGA emulation build and in the system testbench, so the controller can be exercised without a physical SRAM. All pin inputs are synchronous to `clk_i`, the same clock that generates `sck`; no synchronizers are used.

## Interface
- `DUMMY_CYCLES`, 6: `sck` rising edges between the last address nibble and the first read-data nibble.
- `clk_i` in 1: system clock; `sck` toggles at most once per `clk_i`.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `sck` in 1: serial clock from the initiator.
- `cs_n` in 1: chip select, active-low.
- `sio_in` in 4: pins from the initiator; `sio_in[0]` is MOSI.
- `sio_out` out 4: data driven toward the initiator; `sio_out[1]` is MISO.
- `sio_oe` out 4: output enable for `sio_out`.
- `mem_adr_o` out 24: byte address.
- `mem_we_o` out 1: one-cycle write strobe.
- `mem_dat_o` out 8: write data, valid with `mem_we_o`.
- `mem_re_o` out 1: one-cycle read strobe.
- `mem_dat_i` in 8: read data, valid exactly one `clk_i` after `mem_re_o`.

## Operation
- Edge detection: register `sck` as `sck_q`. Rise = `!sck_q && sck`. Fall = `sck_q && !sck`. Inputs are sampled only on a rise. Outputs change only on a fall.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- **IDLE**
  - `cs_n` low moves to CMD with the bit counter at 0.
- **CMD**
  - Shift `sio_in[0]` MSB-first on 8 rises.
  - 0xEB or 0x38 moves to ADDR.
  - Any other value moves to IGNORE.
- **ADDR**
  - Shift the 4-bit `sio_in` MSB-nibble-first on 6 rises to form a 24-bit address.
  - Write command moves to WDATA.
  - Read command moves to DUMMY and pulses `mem_re_o` with `mem_adr_o` equal to the address.
  - The fetched byte is latched into a prefetch register.
- **DUMMY**
  - Count `DUMMY_CYCLES` rises with `sio_oe` = 0000.
  - The last counted rise moves to RDATA.
- **RDATA** (burst continues until `cs_n` rises)
  - First fall: `sio_oe` = 1111, `sio_out` = prefetch[7:4], prefetch copied to the tx register.
  - Same cycle: pulse `mem_re_o` with address+1 and refill the prefetch register.
  - Next fall: `sio_out` = tx[3:0].
  - Falls keep alternating between these two steps. The address increments once per byte.
- **WDATA**
  - Rise 1 captures the high nibble. Rise 2 captures the low nibble.
  - On the cycle after rise 2: pulse `mem_we_o` with the current address and the assembled byte, then increment the address. Further byte pairs repeat this.
- **IGNORE**
  - Hold `sio_oe` = 0000.
  - No memory strobes until `cs_n` rises.
- `cs_n` high in any state: next cycle in IDLE with `sio_oe` = 0000 and counters cleared.
  - A half-received write byte is discarded and no strobe is issued.
  - An in-flight prefetch is dropped.
- Address arithmetic is 24-bit modulo: 0xFFFFFF+1 = 0x000000.
- `mem_re_o` and `mem_we_o` are never high in the same cycle. Each strobe lasts exactly one `clk_i`.

## Timing
- Reset values: `sio_out` = 0000, `sio_oe` = 0000, `mem_adr_o` = 0, `mem_we_o` = 0, `mem_dat_o` = 0, `mem_re_o` = 0, state = IDLE.
- Reset assertion mid-transaction clears state immediately, with no memory strobe.
- After reset release, the block waits for `cs_n` to go high before it accepts a new transaction.
- Read-data setup: with `sck` toggling every `clk_i`, a nibble registered on a fall is stable for one full `clk_i` before the next rise.
- Prefetch budget: `mem_re_o` is issued on the high-nibble fall and the data is used on the next high-nibble fall, 4 `clk_i` later. Minimum slack at full `sck` rate is 2 `clk_i`.
- Write latency: `mem_we_o` is asserted 1 `clk_i` after the rise that completes a byte.
- `cs_n` rising in the same cycle as a `sck` rise: `cs_n` wins and the sample is discarded.

## Test plan
- Single write: `cs_n` low, cmd 0x38, address 0x012345, data 0xA5, `cs_n` high → exactly one `mem_we_o` with adr 0x012345, dat 0xA5; `sio_oe` stays 0000 throughout.
- Single read: memory[0x000010] = 0x3C, cmd 0xEB, address 0x000010, 6 dummy rises → `sio_out` 0x3 then 0xC on successive falls, `sio_oe` = 1111 only in RDATA, `mem_re_o` for 0x10 and 0x11.
- Burst read with wrap: read at 0xFFFFFE for 4 bytes → bytes from 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001 in order; `sio_oe` = 0000 the cycle after `cs_n` rises.
- Aborted write: cmd 0x38, address 0x000100, bytes 0x11 then high nibble 0x2, `cs_n` high → one `mem_we_o` (0x100, 0x11), no second strobe; the next transaction decodes normally.
- Unknown command 0x9F followed by 20 clocks → no `mem_re_o`/`mem_we_o`, `sio_oe` = 0000; after `cs_n` toggles, a 0xEB read succeeds.
- Loopback against the team's SPI controller: wishbone write 0x5A to 0x000042, then burst read → controller returns 0x5A with ack; reset asserted mid-read returns all outputs to reset values within the same cycle.

Source files
------------

// File: rtl/qspi_sram_responder.sv
// QSPI SRAM emulator: decodes 0x38 quad-write / 0xEB quad-read on the pins and
// turns them into byte strobes on a simple synchronous memory port.
module qspi_sram_responder #(
  parameter int unsigned DUMMY_CYCLES = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sck,
  input  logic        cs_n,
  input  logic [3:0]  sio_in,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  output logic [23:0] mem_adr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_dat_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_e;

  localparam logic [7:0]  CMD_QREAD  = 8'hEB;
  localparam logic [7:0]  CMD_QWRITE = 8'h38;
  localparam int unsigned CNT_MAX    = (DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic               sck_q;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               is_rd_q, is_rd_d;
  logic [23:0]        addr_q, addr_d;
  logic [3:0]         wr_hi_q, wr_hi_d;
  logic               wr_half_q, wr_half_d;
  logic               rd_lo_q, rd_lo_d;
  logic [7:0]         prefetch_q, prefetch_d;
  logic [7:0]         tx_q, tx_d;
  logic               pend_q, pend_d;
  logic [3:0]         sio_out_q, sio_out_d;
  logic [3:0]         sio_oe_q, sio_oe_d;
  logic [23:0]        mem_adr_q, mem_adr_d;
  logic               mem_we_q, mem_we_d;
  logic [7:0]         mem_dat_q, mem_dat_d;
  logic               mem_re_q, mem_re_d;

  logic               rise, fall;
  logic [7:0]         cmd_shift;
  logic [23:0]        addr_shift;
  logic [23:0]        addr_inc;

  assign rise       = !sck_q && sck;
  assign fall       = sck_q && !sck;
  assign cmd_shift  = {cmd_q[6:0], sio_in[0]};
  assign addr_shift = {addr_q[19:0], sio_in};
  assign addr_inc   = addr_q + 24'd1;

  always_comb begin
    // NOTE: every _d starts from its _q (strobes from 0) so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    armed_d    = armed_q | cs_n;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    wr_hi_d    = wr_hi_q;
    wr_half_d  = wr_half_q;
    rd_lo_d    = rd_lo_q;
    prefetch_d = prefetch_q;
    tx_d       = tx_q;
    pend_d     = mem_re_q;
    sio_out_d  = sio_out_q;
    sio_oe_d   = sio_oe_q;
    mem_adr_d  = mem_adr_q;
    mem_we_d   = 1'b0;
    mem_dat_d  = mem_dat_q;
    mem_re_d   = 1'b0;

    if (cs_n) begin
      // Deselect wins over any same-cycle sck edge: partial bytes and in-flight fetches are dropped.
      state_d   = S_IDLE;
      cnt_d     = '0;
      wr_half_d = 1'b0;
      rd_lo_d   = 1'b0;
      pend_d    = 1'b0;
      sio_oe_d  = 4'h0;
      sio_out_d = 4'h0;
    end else begin
      if (pend_q) prefetch_d = mem_dat_i;

      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end

        S_CMD: begin
          if (rise) begin
            cmd_d = cmd_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              if (cmd_shift == CMD_QREAD) begin
                is_rd_d = 1'b1;
                state_d = S_ADDR;
              end else if (cmd_shift == CMD_QWRITE) begin
                is_rd_d = 1'b0;
                state_d = S_ADDR;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end

        S_ADDR: begin
          if (rise) begin
            addr_d = addr_shift;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(5)) begin
              cnt_d = '0;
              if (is_rd_q) begin
                state_d   = S_DUMMY;
                mem_re_d  = 1'b1;
                mem_adr_d = addr_shift;
              end else begin
                state_d   = S_WDATA;
                wr_half_d = 1'b0;
              end
            end
          end
        end

        S_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              rd_lo_d = 1'b0;
              state_d = S_RDATA;
            end
          end
        end

        S_RDATA: begin
          if (fall) begin
            if (!rd_lo_q) begin
              // High-nibble fall: ship the prefetched byte and fetch the next one.
              sio_oe_d  = 4'hF;
              sio_out_d = prefetch_q[7:4];
              tx_d      = prefetch_q;
              mem_re_d  = 1'b1;
              mem_adr_d = addr_inc;
              addr_d    = addr_inc;
              rd_lo_d   = 1'b1;
            end else begin
              sio_out_d = tx_q[3:0];
              rd_lo_d   = 1'b0;
            end
          end
        end

        S_WDATA: begin
          if (rise) begin
            if (!wr_half_q) begin
              wr_hi_d   = sio_in;
              wr_half_d = 1'b1;
            end else begin
              mem_we_d  = 1'b1;
              mem_dat_d = {wr_hi_q, sio_in};
              mem_adr_d = addr_q;
              addr_d    = addr_inc;
              wr_half_d = 1'b0;
            end
          end
        end

        S_IGNORE: begin
          sio_oe_d = 4'h0;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers take non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sck_q      <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      cmd_q      <= 8'h00;
      is_rd_q    <= 1'b0;
      addr_q     <= 24'h0;
      wr_hi_q    <= 4'h0;
      wr_half_q  <= 1'b0;
      rd_lo_q    <= 1'b0;
      prefetch_q <= 8'h00;
      tx_q       <= 8'h00;
      pend_q     <= 1'b0;
      sio_out_q  <= 4'h0;
      sio_oe_q   <= 4'h0;
      mem_adr_q  <= 24'h0;
      mem_we_q   <= 1'b0;
      mem_dat_q  <= 8'h00;
      mem_re_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wr_hi_q    <= wr_hi_d;
      wr_half_q  <= wr_half_d;
      rd_lo_q    <= rd_lo_d;
      prefetch_q <= prefetch_d;
      tx_q       <= tx_d;
      pend_q     <= pend_d;
      sio_out_q  <= sio_out_d;
      sio_oe_q   <= sio_oe_d;
      mem_adr_q  <= mem_adr_d;
      mem_we_q   <= mem_we_d;
      mem_dat_q  <= mem_dat_d;
      mem_re_q   <= mem_re_d;
    end
  end

  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_we_o  = mem_we_q;
  assign mem_dat_o = mem_dat_q;
  assign mem_re_o  = mem_re_q;

endmodule
